// File: rtl/spectrogram_writer_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spectrogram_writer_pkg
//  Purpose  : Shared geometry and memory-layout rule of the spectrogram row
//             buffer. The writer and the display-side reader both import this
//             package so the address mapping can only change in one place.
//  Contents : buffer geometry constants, writer state type, helpers that split
//             a linear entry index into a one-hot bank and a bank address.
//  Revision : 1.0 - initial release
// ============================================================================
package spectrogram_writer_pkg;

    localparam int FFT_SIZE       = 256;
    localparam int BINS_PER_FFT   = FFT_SIZE / 2;
    localparam int MAG_WIDTH      = 16;
    localparam int DATA_WIDTH     = 4;
    localparam int NO_FFTS        = 50;
    localparam int NO_BANKS       = 2;
    localparam int RAM_ADDR_WIDTH = 12;
    localparam int IDX_WIDTH      = $clog2(NO_FFTS);
    // Linear index L = slot*BINS_PER_FFT + bin spans the whole buffer.
    localparam int LIN_WIDTH      = $clog2(NO_FFTS * BINS_PER_FFT);
    // Bin counter must be able to hold FFT_SIZE itself (saturation value).
    localparam int BIN_CNT_WIDTH  = $clog2(FFT_SIZE + 1);

    typedef enum logic [0:0] {
        ST_ACCEPT    = 1'b0,
        ST_WAIT_TICK = 1'b1
    } wr_state_t;

    // Bank = L / 2^RAM_ADDR_WIDTH, returned one-hot.
    function automatic logic [NO_BANKS-1:0] lin_to_bank(input logic [LIN_WIDTH-1:0] lin);
        return NO_BANKS'(1) << lin[LIN_WIDTH-1:RAM_ADDR_WIDTH];
    endfunction

    // Address = L mod 2^RAM_ADDR_WIDTH.
    function automatic logic [RAM_ADDR_WIDTH-1:0] lin_to_addr(input logic [LIN_WIDTH-1:0] lin);
        return lin[RAM_ADDR_WIDTH-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/spectrogram_writer_mag_log2_quant.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mag_log2_quant
//  Purpose  : Combinational log2 compressor. Returns the position of the most
//             significant set bit of the magnitude (floor log2), 0 for a zero
//             input, saturated to the largest code the output can hold.
//  Ports    : i_mag  - unsigned magnitude
//             o_code - compressed pixel code
//  Revision : 1.0 - initial release
// ============================================================================
module mag_log2_quant #(
    parameter int MAG_WIDTH  = 16,
    parameter int DATA_WIDTH = 4
) (
    input  logic [MAG_WIDTH-1:0]  i_mag,
    output logic [DATA_WIDTH-1:0] o_code
);

    localparam int POS_WIDTH  = (MAG_WIDTH > 1) ? $clog2(MAG_WIDTH) : 1;
    localparam int C_MAX_CODE = (2 ** DATA_WIDTH) - 1;

    logic [POS_WIDTH-1:0] w_pos;

    // Leading-one search: later (higher) set bits overwrite earlier ones.
    always_comb begin
        w_pos = '0;
        for (int i = 0; i < MAG_WIDTH; i++) begin
            if (i_mag[i]) begin
                w_pos = POS_WIDTH'(i);
            end
        end
    end

    assign o_code = (int'(w_pos) > C_MAX_CODE) ? DATA_WIDTH'(C_MAX_CODE)
                                               : DATA_WIDTH'(w_pos);

endmodule

`default_nettype wire

// File: rtl/spectrogram_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : spectrogram_writer
//  Purpose  : Write side of the two-bank circular spectrogram row buffer.
//             Accepts one FFT magnitude frame on a valid/ready stream, stores
//             the log2 code of the lower half-spectrum into the current row,
//             and commits the row (advancing OLDEST_FFT_IDX) only at a display
//             frame boundary so a displayed row never changes mid-frame.
//  Ports    : clk, reset_n (async assert, active low)
//             in_valid/in_ready/in_data/in_last - magnitude stream
//             frame_tick      - vertical-blanking pulse
//             wr_bank/wr_addr/wr_data - RAM write port (wr_bank one-hot)
//             OLDEST_FFT_IDX  - slot currently being overwritten
//             short_frame     - pulse when a frame ends before BINS_PER_FFT
//  Revision : 1.0 - initial release
// ============================================================================
module spectrogram_writer
    import spectrogram_writer_pkg::*;
#(
    parameter int USE_FRAME_SYNC = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [MAG_WIDTH-1:0]      in_data,
    input  logic                      in_last,
    input  logic                      frame_tick,
    output logic [NO_BANKS-1:0]       wr_bank,
    output logic [RAM_ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0]     wr_data,
    output logic [IDX_WIDTH-1:0]      OLDEST_FFT_IDX,
    output logic                      short_frame
);

    localparam logic [BIN_CNT_WIDTH-1:0] C_BINS_PER_FFT = BIN_CNT_WIDTH'(BINS_PER_FFT);
    localparam logic [BIN_CNT_WIDTH-1:0] C_FFT_SIZE     = BIN_CNT_WIDTH'(FFT_SIZE);
    localparam logic [IDX_WIDTH-1:0]     C_LAST_SLOT    = IDX_WIDTH'(NO_FFTS - 1);
    localparam logic [LIN_WIDTH-1:0]     C_ROW_STEP     = LIN_WIDTH'(BINS_PER_FFT);

    wr_state_t                  r_state;
    wr_state_t                  w_state_nxt;
    logic                       w_ready;
    logic                       w_commit;

    logic [BIN_CNT_WIDTH-1:0]   r_bin_cnt;
    logic [IDX_WIDTH-1:0]       r_wr_slot;
    logic [LIN_WIDTH-1:0]       r_row_base;
    logic [IDX_WIDTH-1:0]       r_oldest;
    logic [NO_BANKS-1:0]        r_wr_bank;
    logic [RAM_ADDR_WIDTH-1:0]  r_wr_addr;
    logic [DATA_WIDTH-1:0]      r_wr_data;
    logic                       r_short_frame;

    logic                       w_xfer;
    logic                       w_store;
    logic                       w_short;
    logic [BIN_CNT_WIDTH-1:0]   w_bin_nxt;
    logic [LIN_WIDTH-1:0]       w_lin;
    logic [IDX_WIDTH-1:0]       w_slot_nxt;
    logic [LIN_WIDTH-1:0]       w_row_nxt;
    logic [DATA_WIDTH-1:0]      w_code;

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_ACCEPT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // in_ready depends on the state register only, never on in_valid.
    // A frame_tick seen while still in ACCEPT is deliberately ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_commit    = 1'b0;
        case (r_state)
            ST_ACCEPT: begin
                w_ready = 1'b1;
                if (in_valid && in_last) begin
                    w_state_nxt = ST_WAIT_TICK;
                end
            end
            ST_WAIT_TICK: begin
                if ((USE_FRAME_SYNC == 0) || frame_tick) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_ACCEPT;
                end
            end
            default: begin
                w_state_nxt = ST_ACCEPT;
            end
        endcase
    end

    assign in_ready = w_ready;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    assign w_xfer     = in_valid & w_ready;
    assign w_store    = w_xfer && (r_bin_cnt < C_BINS_PER_FFT);
    assign w_bin_nxt  = r_bin_cnt + 1'b1;
    assign w_short    = w_xfer && in_last && (w_bin_nxt < C_BINS_PER_FFT);
    // Row base is a running register, so the linear index needs only an add.
    assign w_lin      = r_row_base + LIN_WIDTH'(r_bin_cnt);
    assign w_slot_nxt = (r_wr_slot == C_LAST_SLOT) ? '0 : r_wr_slot + 1'b1;
    assign w_row_nxt  = (r_wr_slot == C_LAST_SLOT) ? '0 : r_row_base + C_ROW_STEP;

    mag_log2_quant #(
        .MAG_WIDTH  (MAG_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_quant (
        .i_mag  (in_data),
        .o_code (w_code)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bin_cnt     <= '0;
            r_wr_slot     <= '0;
            r_row_base    <= '0;
            r_oldest      <= '0;
            r_wr_bank     <= '0;
            r_wr_addr     <= '0;
            r_wr_data     <= '0;
            r_short_frame <= 1'b0;
        end else begin
            // Write port registers the transfer: one cycle of latency.
            r_wr_bank     <= w_store ? lin_to_bank(w_lin) : '0;
            if (w_store) begin
                r_wr_addr <= lin_to_addr(w_lin);
                r_wr_data <= w_code;
            end
            r_short_frame <= w_short;

            // Commit and transfer are exclusive: in_ready is low in WAIT_TICK.
            if (w_commit) begin
                r_bin_cnt  <= '0;
                r_wr_slot  <= w_slot_nxt;
                r_row_base <= w_row_nxt;
                r_oldest   <= w_slot_nxt;
            end else if (w_xfer && (r_bin_cnt != C_FFT_SIZE)) begin
                r_bin_cnt  <= w_bin_nxt;
            end
        end
    end

    assign wr_bank        = r_wr_bank;
    assign wr_addr        = r_wr_addr;
    assign wr_data        = r_wr_data;
    assign OLDEST_FFT_IDX = r_oldest;
    assign short_frame    = r_short_frame;

endmodule

`default_nettype wire

// File: tb/tb_spectrogram_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_spectrogram_writer
//  Purpose  : Self-checking bench for spectrogram_writer. A reference model
//             predicts every RAM write from the linear layout rule; a monitor
//             pops predictions as writes appear on the port.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spectrogram_writer;
    import spectrogram_writer_pkg::*;

    logic                      clk;
    logic                      reset_n;
    logic                      in_valid;
    logic                      in_ready;
    logic [MAG_WIDTH-1:0]      in_data;
    logic                      in_last;
    logic                      frame_tick;
    logic [NO_BANKS-1:0]       wr_bank;
    logic [RAM_ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]     wr_data;
    logic [IDX_WIDTH-1:0]      OLDEST_FFT_IDX;
    logic                      short_frame;

    spectrogram_writer #(
        .USE_FRAME_SYNC (1)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .in_last        (in_last),
        .frame_tick     (frame_tick),
        .wr_bank        (wr_bank),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .OLDEST_FFT_IDX (OLDEST_FFT_IDX),
        .short_frame    (short_frame)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int bank_oh;
        int addr;
        int data;
    } wr_t;

    typedef struct {
        logic [15:0] mag;
        int          code;
    } qvec_t;

    wr_t   exp_q[$];
    wr_t   mon_e;
    int    m_slot;
    int    m_bin;
    int    m_short_exp;
    int    short_seen;
    bit    mon_en;
    qvec_t qtab[9];

    // floor(log2) by repeated halving, saturated to the widest code
    function automatic int ref_code(input int x);
        int c;
        c = 0;
        if (x == 0) return 0;
        while (x > 1) begin
            x = x >> 1;
            c++;
        end
        return (c > 15) ? 15 : c;
    endfunction

    task automatic model_xfer(input bit last, input int code);
        int lin;
        if (m_bin < BINS_PER_FFT) begin
            lin = m_slot * BINS_PER_FFT + m_bin;
            exp_q.push_back('{1 << (lin / (1 << RAM_ADDR_WIDTH)),
                              lin % (1 << RAM_ADDR_WIDTH), code});
        end
        if (last && (m_bin + 1 < BINS_PER_FFT)) m_short_exp++;
        if (m_bin < FFT_SIZE) m_bin++;
    endtask

    // ---------------- write-port monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (short_frame) short_seen++;
            if (wr_bank != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write_bank", int'(wr_bank), 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("wr_bank", int'(wr_bank), mon_e.bank_oh);
                    check("wr_addr", int'(wr_addr), mon_e.addr);
                    check("wr_data", int'(wr_data), mon_e.data);
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send_bin(input int d, input bit last, input int code, input bit tick);
        int w;
        @(negedge clk);
        in_valid   = 1'b1;
        in_data    = 16'(d);
        in_last    = last;
        frame_tick = tick;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("ready_timeout", int'(in_ready), 1);
        else model_xfer(last, code);
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        in_last    = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic do_commit(input int tick_delay);
        @(negedge clk);
        check("ready_in_wait", int'(in_ready), 0);
        check("no_early_commit", int'(OLDEST_FFT_IDX), m_slot);
        repeat (tick_delay) @(negedge clk);
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        m_slot = (m_slot + 1) % NO_FFTS;
        m_bin  = 0;
        @(negedge clk);
        check("oldest_idx", int'(OLDEST_FFT_IDX), m_slot);
        check("ready_after_commit", int'(in_ready), 1);
        check("writes_pending", exp_q.size(), 0);
        check("short_frame_count", short_seen, m_short_exp);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d;
        int len;
        int cls;

        qtab[0] = '{16'h0000, 0};
        qtab[1] = '{16'h0001, 0};
        qtab[2] = '{16'h0002, 1};
        qtab[3] = '{16'h0003, 1};
        qtab[4] = '{16'h00FF, 7};
        qtab[5] = '{16'h8000, 15};
        qtab[6] = '{16'hFFFF, 15};
        qtab[7] = '{16'h0100, 8};
        qtab[8] = '{16'h7FFF, 14};

        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; frame_tick = 1'b0;
        mon_en = 1'b0; m_slot = 0; m_bin = 0; m_short_exp = 0; short_seen = 0;

        repeat (2) @(negedge clk);
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_wr_bank", int'(wr_bank), 0);
        check("rst_wr_addr", int'(wr_addr), 0);
        check("rst_wr_data", int'(wr_data), 0);
        check("rst_oldest", int'(OLDEST_FFT_IDX), 0);
        check("rst_short", int'(short_frame), 0);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // Full 256-bin frame, data = bin index; tick coincides with in_last.
        for (int b = 0; b < FFT_SIZE; b++)
            send_bin(b, b == FFT_SIZE - 1, ref_code(b), b == FFT_SIZE - 1);
        // Valid held high while waiting for the tick: nothing accepted.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 16'hFFFF;
            check("ready_held_wait", int'(in_ready), 0);
            check("oldest_tick_on_last", int'(OLDEST_FFT_IDX), 0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        do_commit(0);

        // Quantiser table as a short frame.
        for (int i = 0; i < 9; i++)
            send_bin(int'(qtab[i].mag), i == 8, qtab[i].code, 1'b0);
        do_commit(1);

        // Short frame ending on bin 9.
        for (int b = 0; b < 10; b++) begin
            d = $urandom_range(0, 65535);
            send_bin(d, b == 9, ref_code(d), 1'b0);
        end
        do_commit(2);

        // Reset at bin 60 of slot 3.
        for (int b = 0; b < 60; b++) send_bin(b * 100, 1'b0, ref_code(b * 100), 1'b0);
        @(negedge clk);
        #2;
        check("drained_before_reset", exp_q.size(), 0);
        check("pre_reset_slot", int'(OLDEST_FFT_IDX), 3);
        reset_n = 1'b0;
        #1;
        check("async_rst_wr_bank", int'(wr_bank), 0);
        check("async_rst_wr_addr", int'(wr_addr), 0);
        check("async_rst_wr_data", int'(wr_data), 0);
        check("async_rst_oldest", int'(OLDEST_FFT_IDX), 0);
        check("async_rst_ready", int'(in_ready), 1);
        m_slot = 0;
        m_bin  = 0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int b = 0; b < BINS_PER_FFT; b++) begin
            d = $urandom_range(0, 65535);
            send_bin(d, b == BINS_PER_FFT - 1, ref_code(d), 1'b0);
        end
        do_commit(0);

        // Random frames, enough to cross into bank 1 and wrap the slot index.
        for (int f = 0; f < 52; f++) begin
            cls = $urandom_range(0, 9);
            if (cls < 2)       len = $urandom_range(1, BINS_PER_FFT - 1);
            else if (cls == 2) len = $urandom_range(FFT_SIZE + 1, FFT_SIZE + 40);
            else               len = $urandom_range(BINS_PER_FFT, FFT_SIZE);
            for (int b = 0; b < len; b++) begin
                if ($urandom_range(0, 9) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
                d = $urandom_range(0, 65535) >> $urandom_range(0, 16);
                send_bin(d, b == len - 1, ref_code(d), $urandom_range(0, 5) == 0);
            end
            do_commit($urandom_range(0, 2));
        end

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/spectrogram_writer.md
Name: spectrogram_writer

Overview:
Write side of the spectrogram buffer: the display pipeline reads this buffer via bank select, address and oldest-FFT index.
- Accepts one FFT magnitude frame at a time on a valid/ready stream.
- Compresses each magnitude to a DATA_WIDTH log2 code.
- Writes the lower half-spectrum into the two-bank circular row buffer.
- Publishes OLDEST_FFT_IDX, advancing it only at a display frame boundary so a row never changes mid-frame.

Parameters:
- FFT_SIZE, 256, bins per input frame.
- BINS_PER_FFT, FFT_SIZE/2 = 128, bins stored per row; bins at or above this are consumed but not written.
- MAG_WIDTH, 16, input magnitude width.
- DATA_WIDTH, 4, stored pixel code width.
- NO_FFTS, 50, rows in the circular buffer.
- NO_BANKS, 2, RAM banks.
- RAM_ADDR_WIDTH, 12, address width per bank.
- USE_FRAME_SYNC, 1, 1 = commit waits for frame_tick; 0 = commit on the cycle after the last write.

Ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  magnitude valid.
- in_ready  out  1  block accepts a magnitude this cycle.
- in_data  in  MAG_WIDTH  unsigned magnitude, bin order 0 upward.
- in_last  in  1  marks the final bin of the frame.
- frame_tick  in  1  one-cycle pulse at display vertical blanking (same clk domain).
- wr_bank  out  NO_BANKS  one-hot bank write enable; all zero = no write.
- wr_addr  out  RAM_ADDR_WIDTH  write address.
- wr_data  out  DATA_WIDTH  pixel code.
- OLDEST_FFT_IDX  out  $clog2(NO_FFTS)  slot currently being overwritten, i.e. the oldest row shown at the top.
- short_frame  out  1  one-cycle pulse when in_last arrives before BINS_PER_FFT bins.

Behaviour:
- Reset (async assert, sync release) values:
  - state=ACCEPT, bin_cnt=0, wr_slot=0.
  - OLDEST_FFT_IDX=0, wr_bank=0, wr_addr=0, wr_data=0, short_frame=0.
- Memory layout:
  - Linear index L = wr_slot*BINS_PER_FFT + bin.
  - Bank = L / 2^RAM_ADDR_WIDTH, driven one-hot on wr_bank.
  - wr_addr = L mod 2^RAM_ADDR_WIDTH.
  - 50*128 = 6400 entries, so slots 0..31 fall in bank 0 and slots 32..49 in bank 1.
  - Row base is kept as a running register, advanced by BINS_PER_FFT per commit. No multiplier.
- in_ready = (state==ACCEPT), combinational from the state register only; it has no dependence on in_valid.
- Transfer occurs when in_valid & in_ready.
- On each transfer with bin_cnt < BINS_PER_FFT, the write fires exactly one cycle later (latency 1):
  - wr_bank set to the row's bank.
  - wr_addr = row offset + bin_cnt.
  - wr_data = code(in_data).
- Otherwise wr_bank=0 on the next cycle.
- bin_cnt increments per transfer and saturates at FFT_SIZE.
- Code function:
  - 0 if in_data==0.
  - Otherwise the MSB position of in_data (floor log2), saturated to 2^DATA_WIDTH-1.
  - Example: 0x0001→0, 0x00FF→7, 0x8000→15.
- State machine:
  - ACCEPT: a transfer with in_last moves to WAIT_TICK. short_frame pulses if bin_cnt+1 < BINS_PER_FFT.
  - WAIT_TICK: in_ready=0. frame_tick=1 performs the commit and returns to ACCEPT. With USE_FRAME_SYNC=0 the commit happens on the first WAIT_TICK cycle unconditionally.
  - frame_tick is ignored in ACCEPT, including a tick on the same cycle as the last transfer.
- Commit (single cycle):
  - wr_slot <= (wr_slot==NO_FFTS-1) ? 0 : wr_slot+1.
  - OLDEST_FFT_IDX <= new wr_slot.
  - Row base advances, wrapping to 0 with wr_slot.
  - bin_cnt <= 0.
- Short frame: unwritten bins of the row keep their stale contents; the row is still committed.
- Frames longer than FFT_SIZE without in_last: extra bins are consumed and dropped; no write and no error.
- Reset mid-frame: the partial row is abandoned. Writing restarts at slot 0 and bin 0. RAM is not cleared.
- Writes never occur in WAIT_TICK except the single trailing write of the final transfer on the first WAIT_TICK cycle.

Decomposition:
- Shared package holds NO_FFTS, NO_BANKS, RAM_ADDR_WIDTH, BINS_PER_FFT, IDX_WIDTH and the layout rule. The reader's address mapping uses the same package, so both sides change together.
- One sub-module: mag_log2_quant, a combinational leading-one encoder with saturation, registered by the parent.

Test Plan:
- Full frame, 256 bins with in_data = bin index, USE_FRAME_SYNC=1 → 128 writes:
  - bank 0, addr 0..127; wr_data for bin 5 = 2, for bin 127 = 6.
  - Bins 128..255 produce no write.
  - in_ready=0 after the last bin.
  - OLDEST_FFT_IDX goes 0→1 on the cycle after frame_tick.
- 32 frames committed → 33rd frame writes bank 1, addr 0..127 (L=4096). 50 commits → OLDEST_FFT_IDX wraps 49→0 and the row base returns to bank 0, addr 0.
- Backpressure and alignment:
  - frame_tick asserted on the same cycle as in_last → no commit.
  - Next frame_tick → commit.
  - in_valid held high in WAIT_TICK → no transfer, bin_cnt unchanged.
- Short frame, in_last on bin 9 → 10 writes, short_frame pulses once, commit still occurs on the following frame_tick.
- Quantiser sweep, in_data ∈ {0, 1, 2, 3, 0x00FF, 0x8000, 0xFFFF} → codes {0, 0, 1, 1, 7, 15, 15}.
- reset_n pulsed low mid-frame at bin 60 of slot 3 → outputs go to reset values immediately (asynchronous). Next frame writes from bank 0, addr 0; OLDEST_FFT_IDX=0.
